sum_arbiter: RTL and testbench
==============================

// Module: sum_arbiter
// PURPOSE
//  Shares one 16-bit sum unit (start/busy/y handshake) between NREQ requesters.
//  Round-robin grant, operand capture, start sequencing, completion detection,
//  result return. A watchdog guards against a stalled sum unit.
//  Sits between requester clients and the single sum datapath instance.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  W        16  operand/result width; matches sum unit
//  TIMEOUT  15  max WAIT cycles before error abort (>=2)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  req_valid  in   NREQ     per-requester request; hold with operands until ack
//  req_a      in   NREQ*W   operand a, requester i at [i*W +: W]
//  req_b      in   NREQ*W   operand b, same packing
//  req_ack    out  NREQ     one-hot 1-cycle pulse: operands captured
//  resp_valid out  NREQ     one-hot 1-cycle pulse: result for requester i
//  resp_y     out  W        result, valid with resp_valid
//  resp_err   out  1        timeout flag, valid with resp_valid
//  sum_start  out  1        to sum unit: 1-cycle start pulse
//  sum_a      out  W        to sum unit: held stable from ISSUE until DONE
//  sum_b      out  W        to sum unit: held stable from ISSUE until DONE
//  sum_busy   in   1        from sum unit: high while computing
//  sum_y      in   W        from sum unit: valid in the cycle busy falls
//  idle       out  1        1 when state==IDLE
// BEHAVIOUR
//  Reset: state IDLE; rr pointer 0; req_ack, resp_valid, sum_start=0;
//   resp_y, resp_err, sum_a, sum_b=0; idle=1. In-flight op dropped, no resp.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, all registered.
//  IDLE: if any req_valid: grant first set bit from ptr, wrapping; latch
//   req_a/req_b of winner into sum_a/sum_b, latch id; req_ack[id]=1 next cycle;
//   ptr <= id+1 mod NREQ; -> ISSUE. No req: stay, outputs 0.
//  ISSUE: sum_start=1 exactly one cycle; clear seen_busy, wdog=0; -> WAIT.
//  WAIT: sum_busy=1 sets seen_busy. seen_busy && !sum_busy: resp_y<=sum_y,
//   resp_err<=0, -> RESP. wdog increments each cycle; wdog==TIMEOUT before
//   completion: resp_y<=0, resp_err<=1, -> RESP (covers busy never rising or
//   never falling).
//  RESP: resp_valid[id]=1 one cycle; -> IDLE. Next grant earliest next cycle.
//  Latency with 1-cycle sum unit: grant cycle T, ack T+1, start T+1,
//   busy seen T+2, capture T+3, resp_valid T+4. Throughput 1 op / 5 cycles.
//  req_valid dropped before ack: no grant, no side effect. New/other requests
//   during ISSUE/WAIT/RESP wait; no queueing beyond req_valid.
//  Same requester may re-request after ack; served when rr reaches it again.
//  Arithmetic done solely by sum unit; W-bit wrap, no carry out.
//  sum_a/sum_b never change outside IDLE grant.
// STRUCTURE
//  sum_pkg: state enum (IDLE/ISSUE/WAIT/RESP), W default, id width function.
//  Sub-module rr_arbiter (NREQ): req vector + ptr -> one-hot grant + index.
//  Top: FSM, operand/id regs, watchdog counter, output regs.
// TESTING
//  Single req0 a=16'h0003 b=16'h0004, real sum unit -> ack[0] T+1,
//   resp_valid[0] T+4, resp_y=16'h0007, resp_err=0.
//  req0..3 all valid, a=i, b=16'h0100 -> serviced 0,1,2,3 in order,
//   resp_y=16'h0100+i, 5-cycle spacing, ptr ends at 0.
//  After serving 2, req1 and req3 valid -> grant 3 before 1.
//  Overflow a=16'hFFFF b=16'h0002 -> resp_y=16'h0001, resp_err=0.
//  Stub sum_busy stuck 0 -> resp_valid[id] after TIMEOUT WAIT cycles,
//   resp_err=1, resp_y=0; next request still serviced.
//  rst asserted in WAIT -> next cycle idle=1, all outputs 0, no resp_valid.

Source files
------------

// File: rtl/sum_arbiter_pkg.sv
// Shared types and helpers for the round-robin sum-unit arbiter.
package sum_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int W_DEFAULT = 16;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sum_arbiter_if.sv
// Requester-side and sum-unit-side signals of the arbiter, bundled in one interface.
interface sum_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   resp_valid;
  logic [W-1:0]      resp_y;
  logic              resp_err;
  logic              sum_start;
  logic [W-1:0]      sum_a;
  logic [W-1:0]      sum_b;
  logic              sum_busy;
  logic [W-1:0]      sum_y;

  // slave: the arbiter itself; master: requesters plus the sum unit
  modport slave (
    input  req_valid, req_a, req_b, sum_busy, sum_y,
    output req_ack, resp_valid, resp_y, resp_err, sum_start, sum_a, sum_b
  );

  modport master (
    output req_valid, req_a, req_b, sum_busy, sum_y,
    input  req_ack, resp_valid, resp_y, resp_err, sum_start, sum_a, sum_b
  );
endinterface

// File: rtl/sum_arbiter_rr.sv
// Round-robin picker: first set request at or after ptr, wrapping, as one-hot and index.
module sum_arbiter_rr
  import sum_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);
  localparam logic [IW:0] N_V = (IW+1)'(NREQ);

  logic [NREQ-1:0] rot;
  logic [IW-1:0]   off;
  logic [IW:0]     sum;

  // rot[k] is request (ptr + k) mod NREQ
  assign rot = NREQ'({req, req} >> ptr);

  always_comb begin
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
  end

  assign sum   = {1'b0, ptr} + {1'b0, off};
  assign idx   = (sum >= N_V) ? IW'(sum - N_V) : sum[IW-1:0];
  assign any   = |req;
  assign grant = any ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/sum_arbiter.sv
// Shares one start/busy/y sum unit among NREQ requesters with round-robin grant
// and a watchdog that aborts an operation whose sum unit never completes.
module sum_arbiter
  import sum_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = W_DEFAULT,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  sum_arbiter_if.slave  bus,
  output logic          idle
);
  localparam int IW = id_width(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state_reg, state_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [IW-1:0]   id_reg, id_next;
  logic            seen_busy_reg, seen_busy_next;
  logic [CW-1:0]   wdog_reg, wdog_next;
  logic [W-1:0]    sum_a_reg, sum_a_next;
  logic [W-1:0]    sum_b_reg, sum_b_next;
  logic [W-1:0]    resp_y_reg, resp_y_next;
  logic            resp_err_reg, resp_err_next;
  logic [NREQ-1:0] req_ack_reg, req_ack_next;
  logic [NREQ-1:0] resp_valid_reg, resp_valid_next;
  logic            sum_start_reg, sum_start_next;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = bus.req_a[gi*W +: W];
    assign b_arr[gi] = bus.req_b[gi*W +: W];
  end

  sum_arbiter_rr #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    id_next         = id_reg;
    seen_busy_next  = seen_busy_reg;
    wdog_next       = wdog_reg;
    sum_a_next      = sum_a_reg;
    sum_b_next      = sum_b_reg;
    resp_y_next     = resp_y_reg;
    resp_err_next   = resp_err_reg;
    req_ack_next    = '0;
    resp_valid_next = '0;
    sum_start_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_any) begin
          sum_a_next     = a_arr[grant_idx];
          sum_b_next     = b_arr[grant_idx];
          id_next        = grant_idx;
          req_ack_next   = grant;
          sum_start_next = 1'b1;
          ptr_next       = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          state_next     = ISSUE;
        end
      end
      ISSUE: begin
        seen_busy_next = 1'b0;
        wdog_next      = '0;
        state_next     = WAIT;
      end
      WAIT: begin
        if (bus.sum_busy) seen_busy_next = 1'b1;
        // wdog counts elapsed WAIT cycles; abort falls in the TIMEOUT-th one
        if (seen_busy_reg && !bus.sum_busy) begin
          resp_y_next     = bus.sum_y;
          resp_err_next   = 1'b0;
          resp_valid_next = NREQ'(1) << id_reg;
          state_next      = RESP;
        end else if (wdog_reg == CW'(TIMEOUT - 1)) begin
          resp_y_next     = '0;
          resp_err_next   = 1'b1;
          resp_valid_next = NREQ'(1) << id_reg;
          state_next      = RESP;
        end else begin
          wdog_next = wdog_reg + 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      id_reg         <= '0;
      seen_busy_reg  <= 1'b0;
      wdog_reg       <= '0;
      sum_a_reg      <= '0;
      sum_b_reg      <= '0;
      resp_y_reg     <= '0;
      resp_err_reg   <= 1'b0;
      req_ack_reg    <= '0;
      resp_valid_reg <= '0;
      sum_start_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      id_reg         <= id_next;
      seen_busy_reg  <= seen_busy_next;
      wdog_reg       <= wdog_next;
      sum_a_reg      <= sum_a_next;
      sum_b_reg      <= sum_b_next;
      resp_y_reg     <= resp_y_next;
      resp_err_reg   <= resp_err_next;
      req_ack_reg    <= req_ack_next;
      resp_valid_reg <= resp_valid_next;
      sum_start_reg  <= sum_start_next;
    end
  end

  assign bus.req_ack    = req_ack_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_y     = resp_y_reg;
  assign bus.resp_err   = resp_err_reg;
  assign bus.sum_start  = sum_start_reg;
  assign bus.sum_a      = sum_a_reg;
  assign bus.sum_b      = sum_b_reg;
  assign idle           = (state_reg == IDLE);

endmodule

// File: tb/tb_sum_arbiter.sv
// Bench for sum_arbiter: directed table, hand sequences, and random traffic checked
// against a cycle-level scoreboard of grant order, results and response timing.
module tb_sum_arbiter;
  localparam int NREQ    = 4;
  localparam int W       = 16;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic idle;
  logic stub = 1'b0;
  logic rand_mode = 1'b0;
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  sum_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  sum_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .idle (idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sum unit: one busy cycle after start; stub mode never raises busy
  always @(posedge clk) begin
    if (rst) begin
      bus.sum_busy <= 1'b0;
      bus.sum_y    <= '0;
    end else if (stub) begin
      bus.sum_busy <= 1'b0;
      bus.sum_y    <= 16'hBEEF;
    end else if (bus.sum_busy) begin
      bus.sum_busy <= 1'b0;
    end else if (bus.sum_start) begin
      bus.sum_busy <= 1'b1;
      bus.sum_y    <= bus.sum_a + bus.sum_b;
    end
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_valid[i]       = 1'b1;
    bus.req_a[i*16 +: 16]  = a;
    bus.req_b[i*16 +: 16]  = b;
  endtask

  // ---------------- scoreboard model ----------------
  logic        p_rst = 1'b1;
  logic [3:0]  p_valid = '0;
  logic [15:0] p_a [4];
  logic [15:0] p_b [4];
  int          m_ptr = 0;
  int          free_from = 0;
  int          m_resp_cyc = -1;
  int          m_id = 0;
  logic [15:0] m_y = '0;
  logic        m_err = 1'b0;
  logic [15:0] m_sa = '0;
  logic [15:0] m_sb = '0;

  initial forever begin
    logic [3:0] e_ack;
    logic [3:0] e_resp;
    int         w;
    logic       found;
    @(negedge clk);
    if (p_rst) begin
      m_ptr = 0; m_resp_cyc = -1; free_from = cyc; m_sa = '0; m_sb = '0;
      check_eq("reset_ctl", {bus.req_ack, bus.resp_valid, bus.sum_start, bus.resp_err, idle},
               {4'b0, 4'b0, 1'b0, 1'b0, 1'b1});
      check_eq("reset_data", {bus.resp_y, bus.sum_a}, 32'h0);
      check_eq("reset_sum_b", bus.sum_b, 32'h0);
    end else begin
      e_ack = '0; w = 0; found = 1'b0;
      if (cyc - 1 >= free_from && p_valid != 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!found && p_valid[(m_ptr + k) % NREQ]) begin
            w = (m_ptr + k) % NREQ;
            found = 1'b1;
          end
        end
        e_ack[w]   = 1'b1;
        m_id       = w;
        m_y        = stub ? 16'h0 : 16'((p_a[w] + p_b[w]) % 65536);
        m_err      = stub;
        m_resp_cyc = cyc + (stub ? 1 + TIMEOUT : 3);
        free_from  = m_resp_cyc + 1;
        m_ptr      = (w + 1) % NREQ;
        m_sa       = p_a[w];
        m_sb       = p_b[w];
      end
      if (e_ack != 0 || bus.req_ack != 0 || bus.sum_start) begin
        check_eq("ack", bus.req_ack, e_ack);
        check_eq("start", bus.sum_start, e_ack != 0);
        if (e_ack != 0) check_eq("sum_ops", {bus.sum_a, bus.sum_b}, {m_sa, m_sb});
      end
      e_resp = (cyc == m_resp_cyc) ? 4'(1 << m_id) : 4'b0;
      if (e_resp != 0 || bus.resp_valid != 0) begin
        check_eq("resp_valid", bus.resp_valid, e_resp);
        if (e_resp != 0) begin
          check_eq("resp_y", bus.resp_y, m_y);
          check_eq("resp_err", bus.resp_err, m_err);
          check_eq("sum_hold", {bus.sum_a, bus.sum_b}, {m_sa, m_sb});
          $display("cycle %0d: resp id=%0d y=%h err=%0d", cyc, m_id, bus.resp_y, bus.resp_err);
        end
      end
    end
    p_rst   = rst;
    p_valid = bus.req_valid;
    for (int k = 0; k < NREQ; k++) begin
      p_a[k] = bus.req_a[k*16 +: 16];
      p_b[k] = bus.req_b[k*16 +: 16];
    end
  end

  // ---------------- requester driver ----------------
  initial forever begin
    @(posedge clk);
    #2;
    if (!rand_mode) begin
      bus.req_valid = bus.req_valid & ~bus.req_ack;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_ack[i]) begin
          if ($urandom_range(1) == 1) set_req(i, 16'($urandom), 16'($urandom));
          else bus.req_valid[i] = 1'b0;
        end else if (!bus.req_valid[i]) begin
          if ($urandom_range(3) == 0) set_req(i, 16'($urandom), 16'($urandom));
        end else if ($urandom_range(39) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
  end

  task automatic wait_resp(output int id, output logic [15:0] y, output logic err, output int at);
    id = -1; y = '0; err = 1'b0; at = -1;
    for (int n = 0; n < 200 && id < 0; n++) begin
      @(negedge clk);
      if (bus.resp_valid != 0) begin
        for (int k = 0; k < NREQ; k++) if (bus.resp_valid[k]) id = k;
        y = bus.resp_y; err = bus.resp_err; at = cyc;
      end
    end
    if (id < 0) check_eq("resp_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int          rid, rat, t0, prev, cnt;
    logic [15:0] ry;
    logic        rerr;
    logic        seen;
    tbl[0] = '{0, 16'h0003, 16'h0004, 16'h0007};
    tbl[1] = '{1, 16'hFFFF, 16'h0002, 16'h0001};
    tbl[2] = '{2, 16'h1234, 16'h4321, 16'h5555};
    tbl[3] = '{3, 16'h8000, 16'h8000, 16'h0000};
    tbl[4] = '{0, 16'h00FF, 16'h0001, 16'h0100};
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // single requests: result and 4-cycle request-to-response latency
    for (int v = 0; v < 5; v++) begin
      @(posedge clk); #2;
      set_req(tbl[v].id, tbl[v].a, tbl[v].b);
      t0 = cyc;
      wait_resp(rid, ry, rerr, rat);
      check_eq("tbl_id", rid, tbl[v].id);
      check_eq("tbl_y", ry, tbl[v].y);
      check_eq("tbl_err", rerr, 1'b0);
      check_eq("tbl_latency", rat - t0, 4);
    end

    // ptr is 1 here; rewind to 0 by serving 3, then all four at once
    @(posedge clk); #2; set_req(3, 16'h0, 16'h0);
    wait_resp(rid, ry, rerr, rat);
    @(posedge clk); #2;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'(i), 16'h0100);
    prev = 0;
    for (int k = 0; k < NREQ; k++) begin
      wait_resp(rid, ry, rerr, rat);
      check_eq("all4_order", rid, k);
      check_eq("all4_y", ry, 16'h0100 + 16'(k));
      if (k > 0) check_eq("all4_spacing", rat - prev, 5);
      prev = rat;
    end

    // ptr must be back at 0: req0 wins over req3
    @(posedge clk); #2; set_req(0, 16'h1, 16'h1); set_req(3, 16'h2, 16'h2);
    wait_resp(rid, ry, rerr, rat); check_eq("ptr0_first", rid, 0);
    wait_resp(rid, ry, rerr, rat); check_eq("ptr0_second", rid, 3);

    // after serving 2, requests 1 and 3 -> 3 first
    @(posedge clk); #2; set_req(2, 16'h10, 16'h20);
    wait_resp(rid, ry, rerr, rat); check_eq("serve2", rid, 2);
    @(posedge clk); #2; set_req(1, 16'h11, 16'h1); set_req(3, 16'h33, 16'h3);
    wait_resp(rid, ry, rerr, rat); check_eq("rr_3_first", rid, 3);
    check_eq("rr_3_y", ry, 16'h0036);
    wait_resp(rid, ry, rerr, rat); check_eq("rr_1_second", rid, 1);

    // stuck sum unit: timeout abort, then normal service resumes
    @(posedge clk); #2; stub = 1'b1; set_req(1, 16'h4444, 16'h1111); t0 = cyc;
    wait_resp(rid, ry, rerr, rat);
    check_eq("to_id", rid, 1);
    check_eq("to_err", rerr, 1'b1);
    check_eq("to_y", ry, 16'h0);
    check_eq("to_latency", rat - t0, 2 + TIMEOUT);
    @(posedge clk); #2; stub = 1'b0; set_req(2, 16'h0005, 16'h0006);
    wait_resp(rid, ry, rerr, rat);
    check_eq("after_to_id", rid, 2);
    check_eq("after_to_y", ry, 16'h000B);
    check_eq("after_to_err", rerr, 1'b0);

    // reset while in WAIT drops the operation
    @(posedge clk); #2; stub = 1'b1; set_req(0, 16'h0009, 16'h0009);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = bus.req_ack[0];
    end
    check_eq("rst_ack_seen", seen, 1'b1);
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0; stub = 1'b0;
    @(negedge clk);
    check_eq("rst_idle", idle, 1'b1);
    check_eq("rst_outs", {bus.req_ack, bus.resp_valid, bus.sum_start, bus.resp_err, bus.resp_y}, 32'h0);
    cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.resp_valid != 0) cnt++;
    end
    check_eq("rst_no_resp", cnt, 0);
    @(posedge clk); #2; set_req(3, 16'h0007, 16'h0008);
    wait_resp(rid, ry, rerr, rat);
    check_eq("post_rst_id", rid, 3);
    check_eq("post_rst_y", ry, 16'h000F);

    // random traffic, checked by the scoreboard
    @(posedge clk); #2; rand_mode = 1'b1;
    repeat (1500) @(posedge clk);
    #2; rand_mode = 1'b0; bus.req_valid = '0;
    repeat (40) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
